// File: rtl/cpu_core.sv
// Accumulator CPU core with internal program memory, carry/zero flags, conditional jumps,
// store-to-memory, load-immediate and single-step control.
module cpu_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              busy,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              zero
);

    localparam int unsigned Depth = 1 << ADDR_W;

    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSub = 4'h3;
    localparam logic [3:0] OpSta = 4'h4;
    localparam logic [3:0] OpLdi = 4'h5;
    localparam logic [3:0] OpJmp = 4'h6;
    localparam logic [3:0] OpJc  = 4'h7;
    localparam logic [3:0] OpJz  = 4'h8;
    localparam logic [3:0] OpOut = 4'he;
    localparam logic [3:0] OpHlt = 4'hf;

    typedef enum logic [2:0] {
        StIdle, StF0, StF1, StE0, StE1, StE2, StHalted
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] mem [Depth];
    logic [ADDR_W-1:0] pc_q, mar_q;
    logic [DATA_W-1:0] ir_q, a_q, b_q, out_q;
    logic              out_valid_q, carry_q, zero_q;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] imm, mem_rd, alu_b;
    logic [DATA_W:0]   sum;
    logic              is_sub;

    assign opcode  = ir_q[DATA_W-1 -: 4];
    assign operand = ir_q[ADDR_W-1:0];
    assign imm     = {4'b0000, ir_q[DATA_W-5:0]};
    assign mem_rd  = mem[mar_q];

    // SUB is A + ~B + 1, so carry-out doubles as "no borrow".
    assign is_sub = (opcode == OpSub);
    assign alu_b  = is_sub ? ~b_q : b_q;
    assign sum    = {1'b0, a_q} + {1'b0, alu_b} + {{DATA_W{1'b0}}, is_sub};

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // STA owns the write port during E1; program load only outside execution, so no overlap.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = prog_addr;
        mem_wdata = prog_data;
        if (state_q == StE1 && opcode == OpSta) begin
            mem_we    = rst;
            mem_waddr = mar_q;
            mem_wdata = a_q;
        end else if (prog_we && (state_q == StIdle || state_q == StHalted)) begin
            mem_we = rst;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (run || step) begin
                        state_q <= StF0;
                    end
                end
                StF0: begin
                    mar_q   <= pc_q;
                    state_q <= StF1;
                end
                StF1: begin
                    ir_q    <= mem_rd;
                    pc_q    <= pc_q + 1'b1;
                    state_q <= StE0;
                end
                StE0: begin
                    state_q <= StE1;
                    case (opcode)
                        OpLda, OpAdd, OpSub, OpSta: mar_q <= operand;
                        OpLdi: a_q  <= imm;
                        OpJmp: pc_q <= operand;
                        OpJc:  if (carry_q) pc_q <= operand;
                        OpJz:  if (zero_q) pc_q <= operand;
                        OpOut: begin
                            out_q       <= a_q;
                            out_valid_q <= 1'b1;
                        end
                        OpHlt: state_q <= StHalted;
                        default: ;
                    endcase
                end
                StE1: begin
                    state_q <= StE2;
                    if (opcode == OpLda) begin
                        a_q <= mem_rd;
                    end else if (opcode == OpAdd || opcode == OpSub) begin
                        b_q <= mem_rd;
                    end
                end
                StE2: begin
                    if (opcode == OpAdd || opcode == OpSub) begin
                        a_q     <= sum[DATA_W-1:0];
                        carry_q <= sum[DATA_W];
                        zero_q  <= (sum[DATA_W-1:0] == '0);
                    end
                    state_q <= run ? StF0 : StIdle;
                end
                StHalted: state_q <= StHalted;
                default:  state_q <= StIdle;
            endcase
        end
    end

    assign out_data  = out_q;
    assign out_valid = out_valid_q;
    assign halted    = (state_q == StHalted);
    assign busy      = (state_q inside {StF0, StF1, StE0, StE1, StE2});
    assign pc        = pc_q;
    assign acc       = a_q;
    assign carry     = carry_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cpu_core.sv
// Randomised and directed bench for cpu_core against an instruction-level reference model,
// covering an 8-bit/4-bit instance and a 16-bit/8-bit instance.
module tb_cpu_core;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       run8 = 1'b0, step8 = 1'b0, pwe8 = 1'b0;
    logic [3:0] paddr8 = '0;
    logic [7:0] pdata8 = '0;
    logic [7:0] od8, acc8;
    logic [3:0] pc8;
    logic       ov8, h8, b8, c8, z8;

    logic        run16 = 1'b0, step16 = 1'b0, pwe16 = 1'b0;
    logic [7:0]  paddr16 = '0;
    logic [15:0] pdata16 = '0;
    logic [15:0] od16, acc16;
    logic [7:0]  pc16;
    logic        ov16, h16, b16, c16, z16;

    cpu_core #(.DATA_W(8), .ADDR_W(4)) u_dut8 (
        .clk(clk), .rst(rst_n), .run(run8), .step(step8), .prog_we(pwe8),
        .prog_addr(paddr8), .prog_data(pdata8), .out_data(od8), .out_valid(ov8),
        .halted(h8), .busy(b8), .pc(pc8), .acc(acc8), .carry(c8), .zero(z8)
    );

    cpu_core #(.DATA_W(16), .ADDR_W(8)) u_dut16 (
        .clk(clk), .rst(rst_n), .run(run16), .step(step16), .prog_we(pwe16),
        .prog_addr(paddr16), .prog_data(pdata16), .out_data(od16), .out_valid(ov16),
        .halted(h16), .busy(b16), .pc(pc16), .acc(acc16), .carry(c16), .zero(z16)
    );

    logic        sel = 1'b0;
    logic [15:0] obs_out, obs_acc;
    logic [7:0]  obs_pc;
    logic        obs_valid, obs_halted, obs_busy, obs_carry, obs_zero;
    assign obs_out    = sel ? od16 : {8'h00, od8};
    assign obs_acc    = sel ? acc16 : {8'h00, acc8};
    assign obs_pc     = sel ? pc16 : {4'h0, pc8};
    assign obs_valid  = sel ? ov16 : ov8;
    assign obs_halted = sel ? h16 : h8;
    assign obs_busy   = sel ? b16 : b8;
    assign obs_carry  = sel ? c16 : c8;
    assign obs_zero   = sel ? z16 : z8;

    int n_checks = 0;
    int n_fail = 0;

    int unsigned mmem [256];
    longint unsigned m_acc, m_pc;
    bit  m_c, m_z, m_halted;
    int  m_end;
    longint unsigned exp_v[$];
    int  exp_k[$];
    longint unsigned got_v[$];
    int  got_k[$];
    int  g_end;
    bit  g_ended;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction-level model: each instruction costs 5 cycles, HLT is seen 3 cycles in.
    task automatic model_run(input int dw, input int aw, input int n);
        longint unsigned dmask = (64'd1 << dw) - 1;
        longint unsigned amask = (64'd1 << aw) - 1;
        longint unsigned imask = (64'd1 << (dw - 4)) - 1;
        longint unsigned mm [256];
        longint unsigned w, opd, v;
        int op;
        for (int a = 0; a < 256; a++) mm[a] = mmem[a];
        m_acc = 0; m_pc = 0; m_c = 0; m_z = 0; m_halted = 0; m_end = 5 * n;
        exp_v.delete(); exp_k.delete();
        for (int i = 0; i < n; i++) begin
            w    = mm[m_pc];
            m_pc = (m_pc + 1) & amask;
            op   = int'(w >> (dw - 4));
            opd  = w & amask;
            case (op)
                1: m_acc = mm[opd];
                2: begin
                    v = m_acc + mm[opd];
                    m_c = (v > dmask); m_acc = v & dmask; m_z = (m_acc == 0);
                end
                3: begin
                    m_c = (m_acc >= mm[opd]);
                    m_acc = (m_acc - mm[opd]) & dmask; m_z = (m_acc == 0);
                end
                4: mm[opd] = m_acc;
                5: m_acc = w & imask;
                6: m_pc = opd;
                7: if (m_c) m_pc = opd;
                8: if (m_z) m_pc = opd;
                14: begin exp_v.push_back(m_acc); exp_k.push_back(5 * i + 3); end
                15: begin m_halted = 1; m_end = 5 * i + 3; break; end
                default: ;
            endcase
        end
    endtask

    task automatic set_run(input logic v);
        if (sel) run16 = v; else run8 = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run8 = 0; run16 = 0; step8 = 0; step16 = 0; pwe8 = 0; pwe16 = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_prog(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            @(negedge clk);
            if (sel) begin
                pwe16 = 1'b1; paddr16 = a[7:0]; pdata16 = mmem[a][15:0];
            end else begin
                pwe8 = 1'b1; paddr8 = a[3:0]; pdata8 = mmem[a][7:0];
            end
        end
        @(negedge clk);
        pwe8 = 1'b0; pwe16 = 1'b0;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) mmem[a] = 0;
    endtask

    // Free-runs the selected core; when the model never halts within n instructions,
    // run drops during instruction n so the core parks in IDLE after it.
    task automatic run_prog(input int n, input string name);
        int dw = sel ? 16 : 8;
        int aw = sel ? 8 : 4;
        int drop_at;
        int cnt;
        model_run(dw, aw, n);
        drop_at = m_halted ? -1 : 5 * (n - 1);
        got_v.delete(); got_k.delete();
        g_ended = 0; g_end = -1;
        @(negedge clk);
        set_run(1'b1);
        for (int k = 0; k <= 5 * n + 10; k++) begin
            @(negedge clk);
            if (obs_valid) begin got_v.push_back(obs_out); got_k.push_back(k); end
            if (k == drop_at) set_run(1'b0);
            if (obs_halted || !obs_busy) begin g_ended = 1; g_end = k; break; end
        end
        set_run(1'b0);
        check_eq({name, ".ended"}, g_ended, 1);
        check_eq({name, ".end_cycle"}, g_end, m_end);
        check_eq({name, ".halted"}, obs_halted, m_halted);
        check_eq({name, ".out_count"}, got_v.size(), exp_v.size());
        cnt = (got_v.size() < exp_v.size()) ? got_v.size() : exp_v.size();
        for (int j = 0; j < cnt; j++) begin
            check_eq($sformatf("%s.out%0d", name, j), got_v[j], exp_v[j]);
            check_eq($sformatf("%s.out%0d_cycle", name, j), got_k[j], exp_k[j]);
        end
        check_eq({name, ".acc"}, obs_acc, m_acc);
        check_eq({name, ".carry"}, obs_carry, m_c);
        check_eq({name, ".zero"}, obs_zero, m_z);
        check_eq({name, ".pc"}, obs_pc, m_pc);
    endtask

    task automatic gen_random(input int dw, input int aw);
        for (int a = 0; a < (1 << aw); a++) begin
            mmem[a] = ($urandom_range(0, 15) << (dw - 4)) | ($urandom & ((1 << (dw - 4)) - 1));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst.pc", pc8, 0);
        check_eq("rst.acc", acc8, 0);
        check_eq("rst.carry", c8, 0);
        check_eq("rst.zero", z8, 0);
        check_eq("rst.out_data", od8, 0);
        check_eq("rst.out_valid", ov8, 0);
        check_eq("rst.busy", b8, 0);
        check_eq("rst.halted", h8, 0);
        check_eq("rst.acc16", acc16, 0);
        check_eq("rst.pc16", pc16, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD and OUT
        clear_mem();
        mmem[0] = 'h1E; mmem[1] = 'h2F; mmem[2] = 'hE0; mmem[3] = 'hF0;
        mmem[14] = 28; mmem[15] = 14;
        load_prog(0, 15);
        run_prog(10, "add_out");
        check_eq("add_out.fixed_out", got_v.size() == 1 ? got_v[0] : 64'hdead, 42);
        check_eq("add_out.fixed_cycle", got_k.size() == 1 ? got_k[0] : -1, 13);
        check_eq("add_out.fixed_halt", g_end, 18);

        // SUB flags: equal and borrow
        do_reset();
        clear_mem();
        mmem[0] = 'h55; mmem[1] = 'h3F; mmem[2] = 'hF0; mmem[15] = 5;
        load_prog(0, 15);
        run_prog(10, "sub_eq");
        check_eq("sub_eq.fixed", {obs_acc, 6'b0, obs_zero, obs_carry}, {16'h0000, 8'h03});
        do_reset();
        mmem[0] = 'h53;
        load_prog(0, 0);
        run_prog(10, "sub_lt");
        check_eq("sub_lt.fixed", {obs_acc, 6'b0, obs_zero, obs_carry}, {16'h00FE, 8'h00});

        // Countdown loop
        do_reset();
        clear_mem();
        mmem[0] = 'h53; mmem[1] = 'hE0; mmem[2] = 'h3F; mmem[3] = 'h85;
        mmem[4] = 'h61; mmem[5] = 'hF0; mmem[15] = 1;
        load_prog(0, 15);
        run_prog(40, "countdown");
        check_eq("countdown.seq", got_v.size() == 3 ? {got_v[0][7:0], got_v[1][7:0], got_v[2][7:0]}
                 : 24'hffffff, 24'h030201);

        // Single step with a spurious pulse while busy
        do_reset();
        clear_mem();
        load_prog(0, 15);
        @(negedge clk);
        step8 = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            step8 = (k == 1);
            check_eq($sformatf("step.busy%0d", k), b8, k < 5);
        end
        check_eq("step.pc1", pc8, 1);
        @(negedge clk);
        check_eq("step.idle", b8, 0);
        step8 = 1'b1;
        @(negedge clk);
        step8 = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("step.pc2", pc8, 2);
        check_eq("step.idle2", b8, 0);

        // Reset during E1 of STA; prog_we while busy is dropped
        do_reset();
        clear_mem();
        mmem[0] = 'h19; mmem[1] = 'h4A; mmem[9] = 'h55; mmem[10] = 'h11;
        mmem[12] = 'h3C; mmem[13] = 'h7E;
        load_prog(0, 15);
        @(negedge clk);
        run8 = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            pwe8 = (k == 6); paddr8 = 4'd12; pdata8 = 8'hAA;
        end
        check_eq("sta.busy_pre", b8, 1);
        check_eq("sta.acc_pre", acc8, 'h55);
        rst_n = 1'b0; run8 = 1'b0; pwe8 = 1'b0;
        #1;
        check_eq("sta.rst_state", {acc8, pc8, od8, ov8, b8, h8, c8, z8}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mmem[0] = 'h1A; mmem[1] = 'hE0; mmem[2] = 'h1C; mmem[3] = 'hE0;
        mmem[4] = 'h1D; mmem[5] = 'hE0; mmem[6] = 'hF0;
        load_prog(0, 6);
        run_prog(10, "readback");
        check_eq("readback.fixed", got_v.size() == 3 ? {got_v[0][7:0], got_v[1][7:0],
                 got_v[2][7:0]} : 24'hffffff, 24'h113C7E);

        // Random programs, 8-bit core
        for (int t = 0; t < 8; t++) begin
            do_reset();
            gen_random(8, 4);
            load_prog(0, 15);
            run_prog(30, $sformatf("rand8_%0d", t));
        end

        // 16-bit core: overflow to zero, JMP to the top address, wrap to 0
        sel = 1'b1;
        do_reset();
        clear_mem();
        mmem[0] = 'h8005; mmem[1] = 'h1080; mmem[2] = 'h2081; mmem[3] = 'h60FF;
        mmem[5] = 'hF000; mmem[255] = 'hE000; mmem[128] = 'hFFFF; mmem[129] = 1;
        load_prog(0, 255);
        run_prog(20, "wide");
        check_eq("wide.fixed", {obs_acc, obs_pc, 6'b0, obs_carry, obs_zero}, {16'h0, 8'h06, 8'h03});
        check_eq("wide.halt_cycle", g_end, 33);

        for (int t = 0; t < 3; t++) begin
            do_reset();
            gen_random(16, 8);
            load_prog(0, 255);
            run_prog(30, $sformatf("rand16_%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
